// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: default data width and
// the occupancy-counter width helper.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // An occupancy counter has to represent 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Small circular register buffer that absorbs words arriving from the FIFO's
// registered read port; the head entry is presented straight from its register.
module fifo_rd_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = 3,
  localparam int OCC_W = occ_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [OCC_W-1:0]  o_occ,
  output logic [DATA_W-1:0] o_head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [OCC_W-1:0]  r_occ;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_tail] <= i_push_data;
        r_tail        <= next_ptr(r_tail);
      end
      if (i_pop) begin
        r_head <= next_ptr(r_head);
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ       = r_occ;
  assign o_head_data = r_mem[r_head];

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_occ <= FULL_OCC);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && (r_occ == FULL_OCC)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side controller for the synchronous FIFO: issues reads, hides the
// one-cycle read latency in a local buffer and presents a valid/ready stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data_out,
  input  logic              fifo_empty,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int OCC_W = occ_w(BUF_DEPTH);

  logic [OCC_W-1:0] w_occ;
  logic             w_room;
  logic             w_pop;
  logic             r_inflight;
  logic [CNT_W-1:0] r_xfer_cnt;

  // Reserve a slot for the word still in flight so a capture never overflows;
  // m_ready is deliberately kept out of this path.
  assign w_room     = (int'(w_occ) + int'(r_inflight)) < BUF_DEPTH;
  assign fifo_rd_en = rst_n && en && !fifo_empty && w_room;

  assign m_valid  = (w_occ != '0);
  assign w_pop    = m_valid && m_ready;
  assign busy     = m_valid || r_inflight;
  assign xfer_cnt = r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (w_pop) begin
        r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
    end
  end

  fifo_rd_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_occ       (w_occ),
    .o_head_data (m_data)
  );

  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_rd_en && fifo_empty));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, a table
// exercises cycle-exact behaviour and a scoreboard checks stream order.
module tb_fifo_rd_stream;

  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_data_out = '0;
  logic              fifo_empty = 1'b1;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  xfer_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_W    (DATA_W),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .busy          (busy),
    .xfer_cnt      (xfer_cnt)
  );

  typedef struct packed {
    logic        en;
    logic        empty;
    logic [7:0]  data;
    logic        ready;
    logic        expRd;
    logic        expValid;
    logic        chkData;
    logic [7:0]  expData;
    logic        expBusy;
    logic [15:0] expCnt;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit useModel = 1'b0;

  logic [7:0] fifoQ[$];
  logic [7:0] expQ[$];
  logic [7:0] gotQ[$];
  int         hsCyc[$];
  int         cyc = 0;
  int         hsTotal = 0;
  int         firstRd = -1;
  int         firstValid = -1;
  int         rdCount = 0;
  logic       prevStall = 1'b0;
  logic [7:0] prevData = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic r);
    en      = e;
    m_ready = r;
  endtask

  task automatic pushWord(input logic [7:0] d);
    fifoQ.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    en      = 1'b0;
    m_ready = 1'b0;
    fifoQ.delete();
    expQ.delete();
    fifo_data_out = '0;
    fifo_empty    = 1'b1;
    prevStall     = 1'b0;
    hsTotal       = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Observe on the falling edge, then advance the FIFO model just after the
  // rising edge so the DUT has already sampled the previous data_out.
  task automatic tick();
    logic rdSeen;
    @(negedge clk);
    rdSeen = fifo_rd_en;
    cyc++;
    if (useModel) begin
      if (fifo_rd_en) begin
        rdCount++;
        if (firstRd < 0) firstRd = cyc;
      end
      if (m_valid && firstValid < 0) firstValid = cyc;
      if (prevStall) begin
        checkOutput("stall_valid_held", 32'(m_valid), 32'd1);
        checkOutput("stall_data_held", 32'(m_data), 32'(prevData));
      end
      if (m_valid && m_ready) begin
        hsCyc.push_back(cyc);
        hsTotal++;
        gotQ.push_back(m_data);
        if (expQ.size() == 0) checkOutput("word_without_read", 32'd0, 32'd1);
        else checkOutput("stream_order", 32'(m_data), 32'(expQ.pop_front()));
      end
      prevStall = m_valid && !m_ready;
      prevData  = m_data;
    end
    @(posedge clk);
    #1;
    if (useModel && rdSeen) begin
      if (fifoQ.size() == 0) begin
        checkOutput("fifo_underflow", 32'd1, 32'd0);
      end else begin
        fifo_data_out = fifoQ.pop_front();
        expQ.push_back(fifo_data_out);
      end
    end
    if (useModel) fifo_empty = (fifoQ.size() == 0);
  endtask

  task automatic drainUntil(input int words, input int budget, input string name);
    int k;
    k = 0;
    while (!(gotQ.size() >= words && !busy) && k < budget) begin
      tick();
      k++;
    end
    checkOutput(name, 32'(gotQ.size() >= words && !busy), 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       vecs[8];
    logic [7:0] refWords[4];
    logic [7:0] rndWords[20];
    int         pushed;
    int         k;

    refWords[0] = 8'h11; refWords[1] = 8'h22;
    refWords[2] = 8'h33; refWords[3] = 8'h44;

    //           en    empty data   ready  rd    valid chk   expData busy  cnt
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'd0};
    vecs[2] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 16'd0};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b1, 16'd0};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 16'd0};
    vecs[5] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 16'd1};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 16'd1};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2};

    // Reset, then idle against an empty FIFO.
    doReset();
    useModel = 1'b1;
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("idle_rd_en", 32'(fifo_rd_en), 32'd0);
      checkOutput("idle_valid", 32'(m_valid), 32'd0);
    end
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_cnt", 32'(xfer_cnt), 32'd0);

    // Cycle-exact vectors with the FIFO port driven directly.
    doReset();
    useModel = 1'b0;
    for (int i = 0; i < 8; i++) begin
      en            = vecs[i].en;
      fifo_empty    = vecs[i].empty;
      fifo_data_out = vecs[i].data;
      m_ready       = vecs[i].ready;
      @(negedge clk);
      checkOutput($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].expRd));
      checkOutput($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vecs[i].expValid));
      if (vecs[i].chkData)
        checkOutput($sformatf("vec%0d_data", i), 32'(m_data), 32'(vecs[i].expData));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(xfer_cnt), 32'(vecs[i].expCnt));
      @(posedge clk);
      #1;
    end

    // Streaming four preloaded words at full rate.
    doReset();
    useModel   = 1'b1;
    firstRd    = -1;
    firstValid = -1;
    hsCyc.delete();
    gotQ.delete();
    for (int i = 0; i < 4; i++) pushWord(refWords[i]);
    applyStimulus(1'b1, 1'b1);
    drainUntil(4, 30, "stream_done");
    checkOutput("first_word_latency", 32'(firstValid - firstRd), 32'd2);
    if (hsCyc.size() >= 4)
      checkOutput("stream_back_to_back", 32'(hsCyc[3] - hsCyc[0]), 32'd3);
    for (int i = 0; i < 4; i++)
      if (i < gotQ.size()) checkOutput("stream_word", 32'(gotQ[i]), 32'(refWords[i]));
    checkOutput("stream_cnt", 32'(xfer_cnt), 32'd4);
    checkOutput("stream_busy_after", 32'(busy), 32'd0);

    // Backpressure: only BUF_DEPTH reads may be outstanding.
    gotQ.delete();
    rdCount = 0;
    for (int i = 0; i < 4; i++) pushWord(refWords[i]);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("bp_reads", 32'(rdCount), 32'd3);
    checkOutput("bp_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_data", 32'(m_data), 32'h11);
    checkOutput("bp_rd_en_off", 32'(fifo_rd_en), 32'd0);
    applyStimulus(1'b1, 1'b1);
    drainUntil(4, 30, "bp_drain_done");
    for (int i = 0; i < 4; i++)
      if (i < gotQ.size()) checkOutput("bp_word", 32'(gotQ[i]), 32'(refWords[i]));
    checkOutput("bp_cnt", 32'(xfer_cnt), 32'd8);

    // en drops right after a read issues; that word must still arrive.
    gotQ.delete();
    rdCount = 0;
    for (int i = 0; i < 4; i++) pushWord(refWords[i]);
    applyStimulus(1'b1, 1'b1);
    tick();
    checkOutput("entog_first_read", 32'(rdCount), 32'd1);
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("entog_no_more_reads", 32'(rdCount), 32'd1);
    checkOutput("entog_words_out", 32'(gotQ.size()), 32'd1);
    if (gotQ.size() > 0) checkOutput("entog_word0", 32'(gotQ[0]), 32'h11);
    checkOutput("entog_idle_busy", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b1);
    drainUntil(4, 30, "entog_resume_done");
    for (int i = 1; i < 4; i++)
      if (i < gotQ.size()) checkOutput("entog_word", 32'(gotQ[i]), 32'(refWords[i]));
    checkOutput("entog_cnt", 32'(xfer_cnt), 32'd12);

    // Random writes, random en and m_ready; order must be preserved.
    doReset();
    gotQ.delete();
    for (int i = 0; i < 20; i++) rndWords[i] = 8'($urandom);
    pushed = 0;
    k = 0;
    while (!(gotQ.size() >= 20 && !busy) && k < 600) begin
      if (pushed < 20 && $urandom_range(0, 3) != 0) begin
        pushWord(rndWords[pushed]);
        pushed++;
      end
      applyStimulus(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
      tick();
      k++;
    end
    checkOutput("rand_done", 32'(gotQ.size() >= 20 && !busy), 32'd1);
    for (int i = 0; i < 20; i++)
      if (i < gotQ.size()) checkOutput("rand_word", 32'(gotQ[i]), 32'(rndWords[i]));
    checkOutput("rand_cnt", 32'(xfer_cnt), 32'd20);

    // Reset with two words buffered and one read in flight.
    gotQ.delete();
    rdCount = 0;
    for (int i = 0; i < 4; i++) pushWord(refWords[i]);
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("prereset_reads", 32'(rdCount), 32'd3);
    checkOutput("prereset_valid", 32'(m_valid), 32'd1);
    checkOutput("prereset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
    checkOutput("reset_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_data", 32'(m_data), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_cnt", 32'(xfer_cnt), 32'd0);
    doReset();
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("postreset_valid", 32'(m_valid), 32'd0);
      checkOutput("postreset_rd_en", 32'(fifo_rd_en), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
